lc3_decode: RTL and testbench
=============================

# lc3_decode

LC-3 decode stage, directly downstream of the fetch stage. When enabled, it captures the instruction word from instruction memory and the fetch stage's incremented PC (`npc_out`). It registers the instruction and produces the execute, writeback and memory control words consumed by the execute and memory-access stages. All outputs are registered, with a one-cycle latency from the enable sample.

## Interface
Parameters:
- `WIDTH`, default 16: instruction and PC width.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `enable_decode`  in  1: capture and decode this cycle.
- `dout`  in  16: instruction word from instruction memory.
- `npc_in`  in  16: next PC from fetch (`npc_out` of fetch).
- `IR`  out  16: registered instruction.
- `npc_out`  out  16: registered `npc_in`.
- `E_Control`  out  6: `{alu_control[1:0], pcselect1[1:0], pcselect2, op2select}`.
- `W_Control`  out  2: writeback source select.
- `Mem_Control`  out  1: indirect-access flag.
- `decode_valid`  out  1: outputs hold a freshly decoded instruction.
- `illegal_op`  out  1: sticky unsupported-opcode flag.
- `illegal_npc`  out  16: `npc_in` of the first illegal instruction.

## Operation
- Registers update only while `enable_decode` = 1; otherwise every output holds its value.
- On each update, `IR` <= `dout` and `npc_out` <= `npc_in`. Control words are decoded from `dout[15:12]`.
- `alu_control`:
  - ADD (0001) = 00, AND (0101) = 01, NOT (1001) = 10.
  - All other opcodes = 00.
- `pcselect1`:
  - 01 (offset9) for BR 0000, LD 0010, LDI 1010, ST 0011, STI 1011, LEA 1110.
  - 10 (offset6) for LDR 0110, STR 0111.
  - 11 (zero) for JMP 1100.
  - 00 otherwise.
- `pcselect2`: 1 (npc base) for BR, LD, LDI, ST, STI, LEA; 0 otherwise.
- `op2select`: 1 only for ADD/AND with `dout[5]` = 0 (register mode); 0 otherwise, including immediate mode and NOT.
- `W_Control`:
  - 00 ALU for ADD/AND/NOT.
  - 01 memory for LD/LDR/LDI.
  - 10 PC-relative for LEA.
  - 00 for all other opcodes.
- `Mem_Control`: 1 for LDI and STI; 0 otherwise.
- Unsupported opcodes decode to all-zero control words: JSR 0100, RTI 1000, reserved 1101, TRAP 1111.
- `decode_valid`: 1 for the cycle after an `enable_decode` = 1 sample; 0 after any cycle with `enable_decode` = 0.

## Timing
- Latency: `dout`/`npc_in` sampled at edge N appear on the outputs after edge N.
- Reset: asynchronous assertion clears every output to 0 immediately: `IR`, `npc_out`, `E_Control`, `W_Control`, `Mem_Control`, `decode_valid`, `illegal_op`, `illegal_npc`.
- Deassertion is taken at the next rising edge. Reset dominates `enable_decode` in the same cycle.
- Reset mid-stream: no residual state survives. The first post-reset capture requires `enable_decode` = 1.
- Back-to-back enables give one decoded instruction per cycle. No bubble is inserted.
- `enable_decode` deasserted for K cycles: outputs frozen for those K cycles; `decode_valid` = 0 from the first frozen cycle.

## Configuration
- Macro: `LC3_DECODE_ILLEGAL_EN`.
- Defined:
  - On an enabled capture of an unsupported opcode, `illegal_op` sets to 1 and `illegal_npc` captures `npc_in`, both on the same edge as `IR`.
  - Both are sticky: later illegal opcodes do not overwrite them. Only reset clears them.
- Undefined: `illegal_op` and `illegal_npc` are constant 0, and no capture logic is built.

## Structure
- Shared package `lc3_pkg`:
  - opcode enum;
  - `alu_control` constants (ADD/AND/NOT);
  - `pcselect1` constants;
  - `W_Control` constants;
  - packed struct type for `E_Control`.
- Sub-module `lc3_ctrl_decoder`: purely combinational, mapping an opcode and `dout[5]` to the E/W/Mem control words plus an illegal indication. `lc3_decode` owns all registers.

## Test plan
- Reset low mid-run with outputs nonzero -> all outputs 0 in the same cycle without a clock edge; they stay 0 until `enable_decode` = 1 after release.
- `dout` = 0x1283 (ADD register), `npc_in` = 0x3001, enable -> next cycle `IR` = 0x1283, `npc_out` = 0x3001, `E_Control` = 0x01, `W_Control` = 00, `Mem_Control` = 0, `decode_valid` = 1.
- Sequence 0x1261, 0x927F, 0x6885, 0xA1FF on consecutive enabled cycles -> `E_Control` 0x00, 0x20, 0x08, 0x06; `W_Control` 00, 00, 01, 01; `Mem_Control` 0, 0, 0, 1.
- Decode 0xC080 (JMP), then drop enable 3 cycles while `dout` changes -> `E_Control` = 0x0C held for 3 cycles; `decode_valid` = 0 during the hold.
- With `LC3_DECODE_ILLEGAL_EN`: 0xF025 (TRAP) at `npc_in` 0x3010, then 0x4800 at 0x3011 -> `illegal_op` = 1, `illegal_npc` = 0x3010 held; control words 0.
- Without the macro, the same stimulus -> `illegal_op` = 0 and `illegal_npc` = 0 throughout.

Source files
------------

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - LC-3 opcode enum and decode control-word encodings
package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PCSEL1_NONE = 2'b00;
  localparam logic [1:0] PCSEL1_OFF9 = 2'b01;
  localparam logic [1:0] PCSEL1_OFF6 = 2'b10;
  localparam logic [1:0] PCSEL1_ZERO = 2'b11;

  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_MEM = 2'b01;
  localparam logic [1:0] WSEL_PC  = 2'b10;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_control_t;

endpackage

// File: rtl/lc3_ctrl_decoder.sv
// rtl/lc3_ctrl_decoder.sv - combinational opcode to E/W/Mem control-word mapping
module lc3_ctrl_decoder
  import lc3_pkg::*;
(
  input  opcode_e    opcode_i,
  input  logic       imm_bit_i,
  output e_control_t e_ctrl_o,
  output logic [1:0] w_ctrl_o,
  output logic       mem_ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    e_ctrl_o   = '0;
    w_ctrl_o   = WSEL_ALU;
    mem_ctrl_o = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        e_ctrl_o.alu_control = ALU_ADD;
        e_ctrl_o.op2select   = ~imm_bit_i;
      end
      OP_AND: begin
        e_ctrl_o.alu_control = ALU_AND;
        e_ctrl_o.op2select   = ~imm_bit_i;
      end
      OP_NOT: e_ctrl_o.alu_control = ALU_NOT;
      OP_BR, OP_ST: begin
        e_ctrl_o.pcselect1 = PCSEL1_OFF9;
        e_ctrl_o.pcselect2 = 1'b1;
      end
      OP_LD, OP_LEA: begin
        e_ctrl_o.pcselect1 = PCSEL1_OFF9;
        e_ctrl_o.pcselect2 = 1'b1;
        w_ctrl_o           = (opcode_i == OP_LEA) ? WSEL_PC : WSEL_MEM;
      end
      OP_LDI, OP_STI: begin
        e_ctrl_o.pcselect1 = PCSEL1_OFF9;
        e_ctrl_o.pcselect2 = 1'b1;
        mem_ctrl_o         = 1'b1;
        w_ctrl_o           = (opcode_i == OP_LDI) ? WSEL_MEM : WSEL_ALU;
      end
      OP_LDR: begin
        e_ctrl_o.pcselect1 = PCSEL1_OFF6;
        w_ctrl_o           = WSEL_MEM;
      end
      OP_STR: e_ctrl_o.pcselect1 = PCSEL1_OFF6;
      OP_JMP: e_ctrl_o.pcselect1 = PCSEL1_ZERO;
      // JSR, RTI, reserved and TRAP are not executed by this pipeline
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_decode.sv
// rtl/lc3_decode.sv - LC-3 decode stage; LC3_DECODE_ILLEGAL_EN enables sticky illegal-opcode capture
module lc3_decode
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_decode,
  input  logic [WIDTH-1:0] dout,
  input  logic [WIDTH-1:0] npc_in,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] npc_out,
  output logic [5:0]       E_Control,
  output logic [1:0]       W_Control,
  output logic             Mem_Control,
  output logic             decode_valid,
  output logic             illegal_op,
  output logic [WIDTH-1:0] illegal_npc
);

  e_control_t       e_ctrl_d, e_ctrl_q;
  logic [1:0]       w_ctrl_d, w_ctrl_q;
  logic             mem_ctrl_d, mem_ctrl_q;
  logic             dec_illegal;
  logic [WIDTH-1:0] ir_q, npc_q;
  logic             valid_q;

  lc3_ctrl_decoder u_ctrl (
    .opcode_i   (opcode_e'(dout[WIDTH-1 -: 4])),
    .imm_bit_i  (dout[5]),
    .e_ctrl_o   (e_ctrl_d),
    .w_ctrl_o   (w_ctrl_d),
    .mem_ctrl_o (mem_ctrl_d),
    .illegal_o  (dec_illegal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q       <= '0;
      npc_q      <= '0;
      e_ctrl_q   <= '0;
      w_ctrl_q   <= '0;
      mem_ctrl_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= enable_decode;
      if (enable_decode) begin
        ir_q       <= dout;
        npc_q      <= npc_in;
        e_ctrl_q   <= e_ctrl_d;
        w_ctrl_q   <= w_ctrl_d;
        mem_ctrl_q <= mem_ctrl_d;
      end
    end
  end

  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign E_Control    = e_ctrl_q;
  assign W_Control    = w_ctrl_q;
  assign Mem_Control  = mem_ctrl_q;
  assign decode_valid = valid_q;

`ifdef LC3_DECODE_ILLEGAL_EN
  logic             ill_op_q;
  logic [WIDTH-1:0] ill_npc_q;

  // Only the first illegal instruction is recorded until the next reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ill_op_q  <= 1'b0;
      ill_npc_q <= '0;
    end else if (enable_decode && dec_illegal && !ill_op_q) begin
      ill_op_q  <= 1'b1;
      ill_npc_q <= npc_in;
    end
  end

  assign illegal_op  = ill_op_q;
  assign illegal_npc = ill_npc_q;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign illegal_op     = 1'b0;
  assign illegal_npc    = '0;
`endif

endmodule

// File: tb/tb_lc3_decode.sv
// tb/tb_lc3_decode.sv - self-checking bench for lc3_decode with a behavioural reference model
module tb_lc3_decode;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_decode = 1'b0;
  logic [15:0] dout = '0;
  logic [15:0] npc_in = '0;
  logic [15:0] IR, npc_out, illegal_npc;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control, decode_valid, illegal_op;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_ir, m_npc, m_illnpc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_m, m_v, m_ill;

  lc3_decode #(.WIDTH(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .dout          (dout),
    .npc_in        (npc_in),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control),
    .decode_valid  (decode_valid),
    .illegal_op    (illegal_op),
    .illegal_npc   (illegal_npc)
  );

  always #5 clock = ~clock;

  wire [58:0] dut_vec = {IR, npc_out, E_Control, W_Control, Mem_Control,
                         decode_valid, illegal_op, illegal_npc};

  function automatic logic [58:0] model_vec();
    return {m_ir, m_npc, m_e, m_w, m_m, m_v, m_ill, m_illnpc};
  endfunction

  // Control words straight from the opcode tables: {E[5:0], W[1:0], Mem}
  function automatic logic [8:0] ref_ctrl(input logic [15:0] instr);
    int op;
    logic [1:0] alu, pc1, w;
    logic pc2, op2, m;
    op  = int'(instr[15:12]);
    alu = (op == 1) ? 2'd0 : (op == 5) ? 2'd1 : (op == 9) ? 2'd2 : 2'd0;
    pc1 = (op inside {0, 2, 3, 10, 11, 14}) ? 2'd1 :
          (op inside {6, 7}) ? 2'd2 : (op == 12) ? 2'd3 : 2'd0;
    pc2 = op inside {0, 2, 3, 10, 11, 14};
    op2 = (op inside {1, 5}) && !instr[5];
    w   = (op inside {2, 6, 10}) ? 2'd1 : (op == 14) ? 2'd2 : 2'd0;
    m   = op inside {10, 11};
    return {alu, pc1, pc2, op2, w, m};
  endfunction

  function automatic logic ref_illegal(input logic [15:0] instr);
    return int'(instr[15:12]) inside {4, 8, 13, 15};
  endfunction

  task automatic model_reset();
    m_ir = '0; m_npc = '0; m_e = '0; m_w = '0; m_m = 1'b0;
    m_v = 1'b0; m_ill = 1'b0; m_illnpc = '0;
  endtask

  // Drive one cycle of inputs, advance past the edge, then update the model
  task automatic tick(input logic en, input logic [15:0] d, input logic [15:0] npc);
    logic [8:0] c;
    enable_decode = en;
    dout = d;
    npc_in = npc;
    @(posedge clock);
    #1;
    m_v = en;
    if (en) begin
      c = ref_ctrl(d);
      m_ir = d; m_npc = npc;
      {m_e, m_w, m_m} = c;
`ifdef LC3_DECODE_ILLEGAL_EN
      if (ref_illegal(d) && !m_ill) begin
        m_ill = 1'b1;
        m_illnpc = npc;
      end
`endif
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_initial got %h exp 0", dut_vec);
    end
    @(negedge clock) reset = 1'b1;
    #4;
    tick(1'b1, 16'h1283, 16'h3001);
    tick(1'b1, 16'hF025, 16'h3002);
    checks++;
    if (dut_vec === '0) begin
      errors++; $display("FAIL reset_preload got %h exp nonzero", dut_vec);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_async got %h exp 0", dut_vec);
    end
    enable_decode = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_dominates got %h exp 0", dut_vec);
    end
    @(negedge clock) reset = 1'b1;
    tick(1'b0, 16'h1283, 16'h1111);
    tick(1'b0, 16'h5555, 16'h2222);
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_hold got %h exp 0", dut_vec);
    end
  endtask

  task automatic test_add_reg();
    tick(1'b1, 16'h1283, 16'h3001);
    checks++;
    if ({IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid} !==
        {16'h1283, 16'h3001, 6'h01, 2'b00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_reg got IR=%h npc=%h E=%h W=%h M=%b V=%b exp 1283 3001 01 0 0 1",
               IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] instr [4] = '{16'h1261, 16'h927F, 16'h6885, 16'hA1FF};
    logic [5:0]  exp_e [4] = '{6'h00, 6'h20, 6'h08, 6'h06};
    logic [1:0]  exp_w [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        exp_m [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, instr[i], 16'h3100 + 16'(i));
      checks++;
      if ({E_Control, W_Control, Mem_Control, decode_valid, IR} !==
          {exp_e[i], exp_w[i], exp_m[i], 1'b1, instr[i]}) begin
        errors++;
        $display("FAIL sequence_%0d got E=%h W=%h M=%b V=%b IR=%h exp E=%h W=%h M=%b V=1 IR=%h",
                 i, E_Control, W_Control, Mem_Control, decode_valid, IR,
                 exp_e[i], exp_w[i], exp_m[i], instr[i]);
      end
    end
  endtask

  task automatic test_hold();
    tick(1'b1, 16'hC080, 16'h3200);
    checks++;
    if (E_Control !== 6'h0C || decode_valid !== 1'b1) begin
      errors++; $display("FAIL jmp_decode got E=%h V=%b exp E=0c V=1", E_Control, decode_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 16'(32'h1000 * (k + 1) + 32'h123), 16'h4000 + 16'(k));
      checks++;
      if ({E_Control, decode_valid, IR, npc_out} !== {6'h0C, 1'b0, 16'hC080, 16'h3200}) begin
        errors++;
        $display("FAIL hold_%0d got E=%h V=%b IR=%h npc=%h exp E=0c V=0 IR=c080 npc=3200",
                 k, E_Control, decode_valid, IR, npc_out);
      end
    end
  endtask

  task automatic test_illegal();
    logic       exp_ill;
    logic [15:0] exp_npc;
`ifdef LC3_DECODE_ILLEGAL_EN
    exp_ill = 1'b1; exp_npc = 16'h3010;
`else
    exp_ill = 1'b0; exp_npc = 16'h0000;
`endif
    tick(1'b1, 16'hF025, 16'h3010);
    checks++;
    if ({illegal_op, illegal_npc, E_Control, W_Control, Mem_Control} !==
        {exp_ill, exp_npc, 6'h00, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL illegal_trap got ill=%b npc=%h E=%h W=%h M=%b exp ill=%b npc=%h ctrl 0",
               illegal_op, illegal_npc, E_Control, W_Control, Mem_Control, exp_ill, exp_npc);
    end
    tick(1'b1, 16'h4800, 16'h3011);
    tick(1'b0, 16'hD000, 16'h3012);
    checks++;
    if ({illegal_op, illegal_npc, E_Control} !== {exp_ill, exp_npc, 6'h00}) begin
      errors++;
      $display("FAIL illegal_sticky got ill=%b npc=%h E=%h exp ill=%b npc=%h E=00",
               illegal_op, illegal_npc, E_Control, exp_ill, exp_npc);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) begin
      tick(1'b1, 16'($urandom), 16'($urandom));
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL back_to_back_%0d got %h exp %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_random();
    @(negedge clock) reset = 1'b0;
    model_reset();
    @(negedge clock) reset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL random_%0d got %h exp %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add_reg();
    test_sequence();
    test_hold();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
